data_memory_controller: RTL and testbench
=========================================

Name: data_memory_controller

Overview:
- MEM-stage responder for the pipeline's 4-bit READ_WRITE memory request code. It performs RV32IM loads and stores (byte, half and word, with sign or zero extension) against an internal byte-addressed memory.
- It drives BUSYWAIT back to every pipeline register so that the whole pipeline stalls for the duration of the access.
- It sits between the EX/MEM register outputs (request, address = ALU result, store data) and the MEM/WB register inputs (READ_DATA).

Parameters:
- ADDR_WIDTH, 10, word-address width; memory depth is 2^ADDR_WIDTH 32-bit words (4 KiB by default).
- LATENCY, 3, number of ACCESS cycles per request; legal range 1..15.

Ports:
- CLK  input  1  clock; all state changes on the posedge.
- RESET  input  1  synchronous, active-high reset.
- READ_WRITE  input  4  request code (see Behaviour).
- ADDRESS  input  32  byte address.
- WRITE_DATA  input  32  store data; the low byte/half is used for SB/SH.
- READ_DATA  output  32  registered, extended load result.
- BUSYWAIT  output  1  stall to the pipeline registers; high while a request is pending.
- MISALIGNED  output  1  one-cycle flag, high in DONE for a misaligned access.

Behaviour:
- Request encoding:
  - 4'b0000 = idle.
  - 4'b1fff = load; fff = funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - 4'b01ss = store; ss: 00 SB, 01 SH, 10 SW.
  - All other codes (1011, 1110, 1111, 0111, 0001..0011) are idle: BUSYWAIT stays 0 and there is no effect.
- Address use: word index = ADDRESS[ADDR_WIDTH+1:2]; upper bits are ignored (aliasing/wrap, no error). Byte lane = ADDRESS[1:0]; little-endian.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if the request is valid, latch READ_WRITE, ADDRESS and WRITE_DATA, load cnt = LATENCY-1, and go to ACCESS.
  - ACCESS: if cnt == 0, execute the access and go to DONE; otherwise decrement cnt.
  - DONE: unconditionally go to IDLE.
- BUSYWAIT is combinational: high when (state==IDLE and request valid) or state==ACCESS; low in DONE and whenever RESET=1.
  - A request therefore sees BUSYWAIT high for LATENCY+1 cycles, then one low cycle (DONE), in which the pipeline advances.
- Latched request only: changes on the inputs during ACCESS are ignored.
  - In DONE, input changes do not start a new access.
  - A new request is first seen in the IDLE cycle that follows DONE; back-to-back memory instructions each pay the full latency.
- Execute (at the ACCESS->DONE edge):
  - Loads: READ_DATA <= the selected byte/half/word; LB/LH sign-extend, LBU/LHU zero-extend.
  - Stores: only the addressed byte lanes are written. SB writes lane ADDRESS[1:0]; SH writes lanes {1,0} or {3,2}.
  - Stores leave READ_DATA unchanged.
- READ_DATA holds its value until the next completed load; it is valid from DONE onward.
- Misaligned access:
  - Definition: LH/LHU/SH with ADDRESS[0]=1; LW/SW with ADDRESS[1:0]!=0.
  - Timing is unchanged.
  - No memory write occurs.
  - A misaligned load sets READ_DATA=0.
  - MISALIGNED=1 during the DONE cycle only.
- Reset (synchronous):
  - state=IDLE, cnt=0, READ_DATA=0, MISALIGNED=0; BUSYWAIT is 0 while RESET is high.
  - Memory contents are not reset.
  - Reset during ACCESS aborts the request, and a pending store is not written.
  - After RESET is deasserted, a still-valid request restarts from IDLE with the full latency.

Test Plan:
- Reset and idle: RESET high for 2 cycles with READ_WRITE=1010 -> BUSYWAIT=0, READ_DATA=0, MISALIGNED=0. Release reset -> BUSYWAIT rises in the same cycle.
- SW then LW: SW addr 0x10, data 0xDEADBEEF, then LW addr 0x10 -> each holds BUSYWAIT high exactly 4 cycles (LATENCY=3), then one low cycle; READ_DATA=0xDEADBEEF in the LW DONE cycle.
- Byte/half extension: after SW 0x8070F080 at 0x20:
  - LB 0x20 -> 0xFFFFFF80.
  - LBU 0x20 -> 0x00000080.
  - LH 0x22 -> 0xFFFF8070.
  - LHU 0x22 -> 0x00008070.
  - LB 0x21 -> 0xFFFFFFF0.
- Partial stores: SB 0xAA at 0x21 and SH 0x1234 at 0x22 over word 0x00000000 -> LW 0x20 = 0x1234AA00.
- Misaligned and illegal codes:
  - LW 0x22 -> MISALIGNED pulses 1 cycle in DONE, READ_DATA=0.
  - SH 0x21 data 0xFFFF -> memory unchanged.
  - Code 4'b1111 -> BUSYWAIT never rises.
- Reset mid-access and input change: assert RESET in the 2nd ACCESS cycle of SW 0x5555AAAA to 0x30 (prior content 0x0) -> later LW 0x30 returns 0x0. Change ADDRESS during an LW ACCESS -> data comes from the originally latched address.

Source files
------------

// File: rtl/data_memory_controller.sv
// MEM-stage load/store responder: latches one request, stalls the pipeline for
// LATENCY access cycles, then performs a byte/half/word access to internal memory.
module data_memory_controller #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  READ_WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [3:0]            r_rw;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_read_data;
  logic                  r_misaligned;
  logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];

  logic                  w_req;
  logic                  w_exec;
  logic                  w_mis;
  logic                  w_we;
  logic [1:0]            w_lane;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_sh;
  logic [31:0]           w_word;
  logic                  w_unused_addr;

  function automatic logic req_valid(input logic [3:0] rw);
    case (rw)
      4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101,
      4'b0100, 4'b0101, 4'b0110: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // Both load funct3 and store ss carry the access size in their low two bits.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return ((size == 2'b01) && lane[0]) || ((size == 2'b10) && (lane != 2'b00));
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  assign w_unused_addr = ^ADDRESS[31:ADDR_WIDTH+2];

  assign w_req    = req_valid(READ_WRITE);
  assign w_exec   = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign w_lane   = r_addr[1:0];
  assign w_idx    = r_addr[ADDR_WIDTH+1:2];
  assign w_mis    = is_misaligned(r_rw[1:0], w_lane);
  assign w_word   = r_mem[w_idx];
  assign BUSYWAIT = !RESET && (((r_state == S_IDLE) && w_req) || (r_state == S_ACCESS));

  always_comb begin
    w_be = 4'b1111;
    case (r_rw[1:0])
      2'b00:   w_be = 4'b0001 << w_lane;
      2'b01:   w_be = 4'b0011 << w_lane;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_wdata_sh = r_wdata << {w_lane, 3'b000};
  // RESET gate drops a store whose final access cycle coincides with reset.
  assign w_we       = w_exec && !r_rw[3] && !w_mis && !RESET;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) w_state_nxt = S_DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_read_data  <= 32'h0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_misaligned <= w_exec && w_mis;
      if (w_exec && r_rw[3])
        r_read_data <= w_mis ? 32'h0 : load_extend(w_word, w_lane, r_rw[2:0]);
    end
  end

  // Request capture: only in IDLE, so inputs are ignored once an access is under way.
  always_ff @(posedge CLK) begin
    if ((r_state == S_IDLE) && w_req) begin
      r_rw    <= READ_WRITE;
      r_addr  <= ADDRESS[ADDR_WIDTH+1:0];
      r_wdata <= WRITE_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
    end
  end

  assign READ_DATA  = r_read_data;
  assign MISALIGNED = r_misaligned;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller: vector table of loads/stores plus
// hand sequences for reset, idle codes, back-to-back and mid-access changes.
module tb_data_memory_controller;

  localparam int LATENCY = 3;

  logic        CLK;
  logic        RESET;
  logic [3:0]  READ_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        MISALIGNED;

  int n_chk = 0;
  int n_err = 0;

  data_memory_controller #(.ADDR_WIDTH(10), .LATENCY(LATENCY)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .READ_WRITE (READ_WRITE),
    .ADDRESS    (ADDRESS),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .BUSYWAIT   (BUSYWAIT),
    .MISALIGNED (MISALIGNED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Starts from IDLE at posedge+1; returns in DONE (keep=1) or back in IDLE.
  task automatic do_req(input string nm, input logic [3:0] rw, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_mis,
                        input bit chg, input bit keep);
    int n;
    READ_WRITE = rw;
    ADDRESS    = a;
    WRITE_DATA = d;
    n = 0;
    #1;
    while (BUSYWAIT && n < 40) begin
      @(posedge CLK); #1;
      n++;
      if (chg && n == 1) begin
        ADDRESS    = a ^ 32'h30;
        READ_WRITE = 4'b0110;
        WRITE_DATA = 32'hFFFFFFFF;
      end
    end
    chk({nm, " busy_cycles"}, 32'(n), 32'(LATENCY + 1));
    chk({nm, " read_data"}, READ_DATA, exp_rd);
    chk({nm, " misaligned"}, {31'h0, MISALIGNED}, {31'h0, exp_mis});
    if (!keep) begin
      READ_WRITE = 4'b0000;
      @(posedge CLK); #1;
      chk({nm, " mis_cleared"}, {31'h0, MISALIGNED}, 32'h0);
      chk({nm, " idle_busy"}, {31'h0, BUSYWAIT}, 32'h0);
    end
  endtask

  initial begin : main
    logic [3:0] idle_codes [7];
    logic       saw_busy;
    int         n;

    vecs.push_back('{4'b0110, 32'h10,       32'hDEADBEEF, 32'h00000000, 1'b0});
    vecs.push_back('{4'b1010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{4'b0110, 32'h20,       32'h8070F080, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{4'b1000, 32'h20,       32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{4'b1100, 32'h20,       32'h0,        32'h00000080, 1'b0});
    vecs.push_back('{4'b1001, 32'h22,       32'h0,        32'hFFFF8070, 1'b0});
    vecs.push_back('{4'b1101, 32'h22,       32'h0,        32'h00008070, 1'b0});
    vecs.push_back('{4'b1000, 32'h21,       32'h0,        32'hFFFFFFF0, 1'b0});
    vecs.push_back('{4'b0110, 32'h20,       32'h00000000, 32'hFFFFFFF0, 1'b0});
    vecs.push_back('{4'b0100, 32'h21,       32'h123456AA, 32'hFFFFFFF0, 1'b0});
    vecs.push_back('{4'b0101, 32'h22,       32'hABCD1234, 32'hFFFFFFF0, 1'b0});
    vecs.push_back('{4'b1010, 32'h20,       32'h0,        32'h1234AA00, 1'b0});
    vecs.push_back('{4'b1010, 32'h22,       32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{4'b0101, 32'h21,       32'h0000FFFF, 32'h00000000, 1'b1});
    vecs.push_back('{4'b1010, 32'h20,       32'h0,        32'h1234AA00, 1'b0});
    vecs.push_back('{4'b1001, 32'h23,       32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{4'b1101, 32'h20,       32'h0,        32'h0000AA00, 1'b0});
    vecs.push_back('{4'b0100, 32'h13,       32'h00000055, 32'h0000AA00, 1'b0});
    vecs.push_back('{4'b1010, 32'h10000010, 32'h0,        32'h55ADBEEF, 1'b0});
    vecs.push_back('{4'b1001, 32'h12,       32'h0,        32'h000055AD, 1'b0});
    vecs.push_back('{4'b1000, 32'h11,       32'h0,        32'hFFFFFFBE, 1'b0});
    vecs.push_back('{4'b0110, 32'h11,       32'hFFFFFFFF, 32'hFFFFFFBE, 1'b1});
    vecs.push_back('{4'b1010, 32'h10,       32'h0,        32'h55ADBEEF, 1'b0});

    idle_codes = '{4'b1111, 4'b1110, 4'b1011, 4'b0111, 4'b0001, 4'b0010, 4'b0011};

    // Reset with a valid load presented
    RESET      = 1'b1;
    READ_WRITE = 4'b1010;
    ADDRESS    = 32'h0;
    WRITE_DATA = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst busy", {31'h0, BUSYWAIT}, 32'h0);
    chk("rst read_data", READ_DATA, 32'h0);
    chk("rst misaligned", {31'h0, MISALIGNED}, 32'h0);
    RESET = 1'b0;
    #1;
    chk("rst release busy", {31'h0, BUSYWAIT}, 32'h1);
    READ_WRITE = 4'b0000;
    @(posedge CLK); #1;
    chk("idle after release", {31'h0, BUSYWAIT}, 32'h0);

    for (int i = 0; i < vecs.size(); i++)
      do_req($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rd, vecs[i].exp_mis, 1'b0, 1'b0);

    // Illegal codes never stall and leave outputs untouched
    for (int c = 0; c < 7; c++) begin
      READ_WRITE = idle_codes[c];
      ADDRESS    = 32'h20;
      WRITE_DATA = 32'hFFFFFFFF;
      saw_busy   = 1'b0;
      for (int k = 0; k < 6; k++) begin
        #1;
        if (BUSYWAIT) saw_busy = 1'b1;
        @(posedge CLK); #1;
      end
      chk($sformatf("code%b busy", idle_codes[c]), {31'h0, saw_busy}, 32'h0);
      chk($sformatf("code%b read_data", idle_codes[c]), READ_DATA, 32'h55ADBEEF);
    end
    READ_WRITE = 4'b0000;
    do_req("after_codes", 4'b1010, 32'h20, 32'h0, 32'h1234AA00, 1'b0, 1'b0, 1'b0);

    // Back-to-back: request held through DONE restarts with full latency
    do_req("b2b_first", 4'b1010, 32'h10, 32'h0, 32'h55ADBEEF, 1'b0, 1'b0, 1'b1);
    @(posedge CLK); #1;
    chk("b2b restart busy", {31'h0, BUSYWAIT}, 32'h1);
    n = 0;
    while (BUSYWAIT && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("b2b second busy_cycles", 32'(n), 32'(LATENCY + 1));
    READ_WRITE = 4'b0000;
    @(posedge CLK); #1;

    // Inputs changed during ACCESS are ignored (latched LW 0x10, no store to 0x20)
    do_req("chg", 4'b1010, 32'h10, 32'h0, 32'h55ADBEEF, 1'b0, 1'b1, 1'b0);
    do_req("chg_verify", 4'b1010, 32'h20, 32'h0, 32'h1234AA00, 1'b0, 1'b0, 1'b0);

    // Reset in the 2nd ACCESS cycle aborts a store
    do_req("pre30", 4'b0110, 32'h30, 32'h00000000, 32'h1234AA00, 1'b0, 1'b0, 1'b0);
    READ_WRITE = 4'b0110;
    ADDRESS    = 32'h30;
    WRITE_DATA = 32'h5555AAAA;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    chk("abort busy", {31'h0, BUSYWAIT}, 32'h0);
    @(posedge CLK); #1;
    chk("abort read_data", READ_DATA, 32'h0);
    RESET      = 1'b0;
    READ_WRITE = 4'b0000;
    @(posedge CLK); #1;
    chk("abort idle busy", {31'h0, BUSYWAIT}, 32'h0);
    do_req("post_abort", 4'b1010, 32'h30, 32'h0, 32'h00000000, 1'b0, 1'b0, 1'b0);
    do_req("final", 4'b1000, 32'h22, 32'h0, 32'h00000034, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
